// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: N-digit BCD countdown with pause, queued penalty drain, MM:SS mode and low-time warning
module bcd_countdown_timer #(
  parameter int DIGITS = 3,
  parameter int MMSS_MODE = 0,
  parameter logic [7:0] PENALTY = 8'd10,
  parameter logic [23:0] WARN_BCD = 24'h000010
)(
  input  logic                clk,
  input  logic                reset,
  input  logic [4*DIGITS-1:0] init_time,
  input  logic                load,
  input  logic                start_stop,
  input  logic                tick,
  input  logic                penalty,
  output logic [4*DIGITS-1:0] value,
  output logic                running,
  output logic                expired,
  output logic                warn
);
  localparam int W = 4*DIGITS;
  typedef enum logic [1:0] {IDLE, PAUSED, RUNNING, EXPIRED} state_t;
  state_t state, state_d;
  logic [W-1:0] value_d, dec_val, clamped;
  logic [7:0] pend, pend_d;
  logic [9:0] pend_sum;
  logic dec, brw;
  assign dec = (pend != 8'd0) && (value != '0);
  // borrow ripples from digit 0 upward; digit 1 wraps to 5 in MM:SS mode
  always_comb begin
    dec_val = value;
    clamped = init_time;
    brw = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      dec_val[4*i+:4] = !brw ? value[4*i+:4] :
                        (value[4*i+:4] == 4'd0) ? ((MMSS_MODE != 0 && i == 1) ? 4'd5 : 4'd9) :
                        value[4*i+:4] - 4'd1;
      brw = brw && (value[4*i+:4] == 4'd0);
      clamped[4*i+:4] = (init_time[4*i+:4] > ((MMSS_MODE != 0 && i == 1) ? 4'd5 : 4'd9)) ?
                        ((MMSS_MODE != 0 && i == 1) ? 4'd5 : 4'd9) : init_time[4*i+:4];
    end
  end
  assign pend_sum = {2'b00, pend}
                  + {9'd0, tick && state == RUNNING}
                  + ((penalty && (state == RUNNING || state == PAUSED)) ? {2'b00, PENALTY} : 10'd0)
                  - {9'd0, dec};
  always_comb begin
    state_d = state;
    value_d = value;
    pend_d = (pend_sum > 10'd255) ? 8'd255 : pend_sum[7:0];
    if (load) begin
      value_d = clamped;
      pend_d = 8'd0;
      state_d = (clamped == '0) ? EXPIRED : PAUSED;
    end else begin
      if (dec) value_d = dec_val;
      if (dec && dec_val == '0) begin
        state_d = EXPIRED;
        pend_d = 8'd0;
      end else if (start_stop && state == PAUSED) state_d = RUNNING;
      else if (start_stop && state == RUNNING) state_d = PAUSED;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      value <= '0;
      pend <= 8'd0;
    end else begin
      state <= state_d;
      value <= value_d;
      pend <= pend_d;
    end
  end
  assign running = state == RUNNING;
  assign expired = state == EXPIRED;
  assign warn = (32'(value) <= 32'(WARN_BCD)) && (value != '0);
endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb_bcd_countdown_timer: directed checks of the default 3-digit timer and a 4-digit MM:SS instance
module tb_bcd_countdown_timer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [11:0] init_a = '0;
  logic load_a = 0, ss_a = 0, tick_a = 0, pen_a = 0;
  logic [11:0] value_a;
  logic running_a, expired_a, warn_a;
  logic [15:0] init_b = '0;
  logic load_b = 0, ss_b = 0, tick_b = 0, pen_b = 0;
  logic [15:0] value_b;
  logic running_b, expired_b, warn_b;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  bcd_countdown_timer dut_a (
    .clk(clk), .reset(reset), .init_time(init_a), .load(load_a), .start_stop(ss_a),
    .tick(tick_a), .penalty(pen_a), .value(value_a), .running(running_a),
    .expired(expired_a), .warn(warn_a)
  );

  bcd_countdown_timer #(.DIGITS(4), .MMSS_MODE(1)) dut_b (
    .clk(clk), .reset(reset), .init_time(init_b), .load(load_b), .start_stop(ss_b),
    .tick(tick_b), .penalty(pen_b), .value(value_b), .running(running_b),
    .expired(expired_b), .warn(warn_b)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string name, input logic [11:0] v, input logic r, input logic e, input logic w);
    total++;
    if ({value_a, running_a, expired_a, warn_a} !== {v, r, e, w}) begin
      bad++;
      $display("FAIL %s: got value=%h run=%b exp=%b warn=%b, want value=%h run=%b exp=%b warn=%b",
               name, value_a, running_a, expired_a, warn_a, v, r, e, w);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    chk_a("reset_a", 12'h000, 0, 0, 0);
    total++;
    if ({value_b, running_b, expired_b, warn_b} !== {16'h0000, 3'b000}) begin
      bad++;
      $display("FAIL reset_b: got value=%h flags=%b%b%b want 0000 000", value_b, running_b, expired_b, warn_b);
    end
    reset = 1'b0;
    init_a = 12'h190;
    load_a = 1'b1;
    cyc();
    load_a = 1'b0;
    chk_a("load_190", 12'h190, 0, 0, 0);
  endtask

  task automatic test_count();
    logic [11:0] exp_v [11] = '{12'h189, 12'h188, 12'h187, 12'h186, 12'h185, 12'h184,
                                12'h183, 12'h182, 12'h181, 12'h180, 12'h179};
    logic [11:0] prev = 12'h190;
    ss_a = 1'b1;
    cyc();
    ss_a = 1'b0;
    chk_a("start", 12'h190, 1, 0, 0);
    for (int k = 0; k < 11; k++) begin
      tick_a = 1'b1;
      cyc();
      tick_a = 1'b0;
      chk_a("tick_latency", prev, 1, 0, 0);
      cyc();
      chk_a("tick_step", exp_v[k], 1, 0, 0);
      prev = exp_v[k];
    end
  endtask

  task automatic test_pause();
    ss_a = 1'b1;
    cyc();
    ss_a = 1'b0;
    chk_a("pause", 12'h179, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick_a = 1'b1;
      cyc();
      tick_a = 1'b0;
      cyc();
    end
    chk_a("pause_ticks_ignored", 12'h179, 0, 0, 0);
    ss_a = 1'b1;
    cyc();
    ss_a = 1'b0;
    chk_a("resume", 12'h179, 1, 0, 0);
  endtask

  task automatic test_penalty();
    logic [11:0] exp_v [11] = '{12'h178, 12'h177, 12'h176, 12'h175, 12'h174, 12'h173,
                                12'h172, 12'h171, 12'h170, 12'h169, 12'h168};
    pen_a = 1'b1;
    cyc();
    pen_a = 1'b0;
    chk_a("penalty_edge", 12'h179, 1, 0, 0);
    for (int k = 1; k <= 11; k++) begin
      tick_a = (k == 3);
      cyc();
      chk_a("penalty_drain", exp_v[k-1], 1, 0, 0);
    end
    tick_a = 1'b0;
    cyc();
    cyc();
    chk_a("penalty_done", 12'h168, 1, 0, 0);
  endtask

  task automatic test_expiry();
    logic [11:0] exp_v [12] = '{12'h011, 12'h010, 12'h009, 12'h008, 12'h007, 12'h006,
                                12'h005, 12'h004, 12'h003, 12'h002, 12'h001, 12'h000};
    init_a = 12'h012;
    load_a = 1'b1;
    cyc();
    load_a = 1'b0;
    chk_a("load_012", 12'h012, 0, 0, 0);
    ss_a = 1'b1;
    cyc();
    ss_a = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick_a = 1'b1;
      cyc();
      tick_a = 1'b0;
      cyc();
      if (k < 11) chk_a("countdown_warn", exp_v[k], 1, 0, exp_v[k] <= 12'h010);
      else chk_a("expire", 12'h000, 0, 1, 0);
    end
    tick_a = 1'b1;
    pen_a = 1'b1;
    ss_a = 1'b1;
    cyc();
    tick_a = 1'b0;
    pen_a = 1'b0;
    ss_a = 1'b0;
    cyc();
    cyc();
    chk_a("expired_hold", 12'h000, 0, 1, 0);
  endtask

  task automatic test_back_to_back();
    init_a = 12'h005;
    load_a = 1'b1;
    ss_a = 1'b1;
    cyc();
    load_a = 1'b0;
    ss_a = 1'b0;
    chk_a("load_over_startstop", 12'h005, 0, 0, 1);
    pen_a = 1'b1;
    cyc();
    pen_a = 1'b0;
    for (int k = 0; k < 4; k++) cyc();
    chk_a("paused_drain", 12'h001, 0, 0, 1);
    cyc();
    chk_a("paused_drain_expire", 12'h000, 0, 1, 0);
    init_a = 12'hFA3;
    load_a = 1'b1;
    cyc();
    load_a = 1'b0;
    chk_a("clamp_3dig", 12'h993, 0, 0, 0);
  endtask

  task automatic test_mmss();
    init_b = 16'h0100;
    load_b = 1'b1;
    cyc();
    load_b = 1'b0;
    ss_b = 1'b1;
    cyc();
    ss_b = 1'b0;
    tick_b = 1'b1;
    cyc();
    tick_b = 1'b0;
    cyc();
    total++;
    if ({value_b, running_b, warn_b} !== {16'h0059, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL mmss_borrow: got value=%h run=%b warn=%b want 0059 1 0", value_b, running_b, warn_b);
    end
    init_b = 16'h097A;
    load_b = 1'b1;
    cyc();
    load_b = 1'b0;
    total++;
    if ({value_b, running_b, expired_b} !== {16'h0959, 2'b00}) begin
      bad++;
      $display("FAIL mmss_clamp: got value=%h run=%b exp=%b want 0959 0 0", value_b, running_b, expired_b);
    end
    init_b = 16'h0000;
    load_b = 1'b1;
    cyc();
    load_b = 1'b0;
    total++;
    if ({value_b, running_b, expired_b, warn_b} !== {16'h0000, 3'b010}) begin
      bad++;
      $display("FAIL mmss_load_zero: got value=%h run=%b exp=%b warn=%b want 0000 0 1 0",
               value_b, running_b, expired_b, warn_b);
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_pause();
    test_penalty();
    test_expiry();
    test_back_to_back();
    test_mmss();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
